// File: rtl/oled_pixel_streamer.sv
// Raster-scans a pixel generator and streams RGB565 words to a 96x64 OLED over SPI mode 0.
// Define OLED_WINDOW_CMD_EN to send a column/row window header before each frame.
module oled_pixel_streamer #(
   parameter int CLK_DIV = 1,
   parameter int WIDTH   = 96,
   parameter int HEIGHT  = 64,
   parameter int GAP     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic [6:0]  x,
   output logic [5:0]  y,
   input  logic [15:0] oled_data,
   output logic        cs_n,
   output logic        sclk,
   output logic        sdin,
   output logic        dc,
   output logic        frame_begin,
   output logic        busy
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_LOAD, S_PIX, S_GAP
   } state_t;

`ifdef OLED_WINDOW_CMD_EN
   localparam logic [47:0] HDR = {8'h15, 8'h00, 8'(WIDTH - 1),
                                  8'h75, 8'h00, 8'(HEIGHT - 1)};
   localparam state_t FIRST = S_CMD;
`else
   localparam state_t FIRST = S_LOAD;
`endif

   state_t         state_q, state_d;
   logic [DW-1:0]  div_q, div_d;
   logic           half_q, half_d;
   logic [5:0]     bit_q, bit_d;
   logic [15:0]    pix_q, pix_d;
   logic [6:0]     x_q, x_d;
   logic [5:0]     y_q, y_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic           fb_q, fb_d;

   logic shifting, half_end, bit_end, gap_done;
   logic start, first_pix, frame_last;

   assign shifting   = (state_q == S_CMD) || (state_q == S_PIX);
   assign half_end   = div_q == DW'(CLK_DIV - 1);
   assign bit_end    = half_end && half_q;
   assign gap_done   = gap_q == GW'(GAP - 1);
   assign start      = enable && ((state_q == S_IDLE) ||
                                  (state_q == S_GAP && gap_done));
   assign first_pix  = (state_q == S_PIX) && (bit_q == 6'd0) &&
                       !half_q && (div_q == '0);
   // x/y already advanced past the pixel being shifted; (0,0) means it was the last one
   assign frame_last = (x_q == 7'd0) && (y_q == 6'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (enable) state_d = FIRST;
         S_CMD:  if (bit_end && bit_q == 6'd47) state_d = S_LOAD;
         S_LOAD: state_d = S_PIX;
         S_PIX:  if (bit_end && bit_q == 6'd15)
                    state_d = frame_last ? S_GAP : S_LOAD;
         S_GAP:  if (gap_done) state_d = enable ? FIRST : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_d  = '0;
      half_d = 1'b0;
      bit_d  = '0;
      pix_d  = pix_q;
      x_d    = x_q;
      y_d    = y_q;
      gap_d  = '0;
      fb_d   = start;
      if (shifting) begin
         div_d  = half_end ? '0 : div_q + DW'(1);
         half_d = half_end ? ~half_q : half_q;
         bit_d  = bit_end ? bit_q + 6'd1 : bit_q;
      end
      if (state_q == S_LOAD) pix_d = oled_data;
      if (state_q == S_GAP)  gap_d = gap_q + GW'(1);
      if (first_pix) begin
         if (x_q == 7'(WIDTH - 1)) begin
            x_d = '0;
            y_d = (y_q == 6'(HEIGHT - 1)) ? '0 : y_q + 6'd1;
         end else begin
            x_d = x_q + 7'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q  <= '0;
         half_q <= 1'b0;
         bit_q  <= '0;
         pix_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
         gap_q  <= '0;
         fb_q   <= 1'b0;
      end else begin
         div_q  <= div_d;
         half_q <= half_d;
         bit_q  <= bit_d;
         pix_q  <= pix_d;
         x_q    <= x_d;
         y_q    <= y_d;
         gap_q  <= gap_d;
         fb_q   <= fb_d;
      end
   end

   always_comb begin
      cs_n = 1'b1;
      busy = 1'b0;
      dc   = 1'b0;
      sclk = 1'b0;
      sdin = 1'b0;
      unique case (state_q)
`ifdef OLED_WINDOW_CMD_EN
         S_CMD: begin
            cs_n = 1'b0;
            busy = 1'b1;
            sclk = half_q;
            sdin = HDR[6'd47 - bit_q];
         end
`endif
         S_LOAD: begin
            cs_n = 1'b0;
            busy = 1'b1;
            dc   = 1'b1;
         end
         S_PIX: begin
            cs_n = 1'b0;
            busy = 1'b1;
            dc   = 1'b1;
            sclk = half_q;
            sdin = pix_q[4'd15 - bit_q[3:0]];
         end
         default: ;
      endcase
   end

   assign x           = x_q;
   assign y           = y_q;
   assign frame_begin = fb_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench for oled_pixel_streamer on a reduced 8x4 raster.
// Decodes the SPI stream on sclk rising and checks header, pixels, gap, wrap and reset.
module tb_oled_pixel_streamer;
   localparam int TW   = 8;
   localparam int TH   = 4;
   localparam int TD   = 2;
   localparam int TG   = 16;
   localparam int NPIX = TW * TH;
   localparam int LIM  = 20000;
`ifdef OLED_WINDOW_CMD_EN
   localparam int EXP_CMD_N = 48;
`else
   localparam int EXP_CMD_N = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [6:0]  x;
   logic [5:0]  y;
   logic [15:0] oled_data;
   logic        cs_n, sclk, sdin, dc, frame_begin, busy;

   always #5 clk = ~clk;

   assign oled_data = (x == 7'd0 && y == 6'd0) ? 16'hFC00 : {x, 3'b000, y};

   oled_pixel_streamer #(
      .CLK_DIV(TD), .WIDTH(TW), .HEIGHT(TH), .GAP(TG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .x(x), .y(y), .oled_data(oled_data),
      .cs_n(cs_n), .sclk(sclk), .sdin(sdin), .dc(dc),
      .frame_begin(frame_begin), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   int          fb_cnt = 0, fb_wide = 0;
   int          cmd_n = 0, bit_n = 0, pix_n = 0;
   int          last_cmd_n = 0, last_pix_n = 0;
   logic [47:0] cmd_sr = '0, last_cmd_sr = '0;
   logic [15:0] word = '0;
   logic [15:0] words [NPIX];
   logic        sclk_prev = 1'b0, fb_prev = 1'b0, busy_prev = 1'b0;

   typedef struct {
      int          px;
      int          py;
      logic [15:0] exp;
   } vec_t;
   vec_t vt [6];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] gen(input int xi, input int yi);
      if (xi == 0 && yi == 0) return 16'hFC00;
      return {7'(xi), 3'b000, 6'(yi)};
   endfunction

   // SPI decoder: samples on sclk rising, seen at the falling clk edge
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cmd_n = 0;
            bit_n = 0;
            pix_n = 0;
         end else begin
            if (frame_begin) begin
               cmd_n = 0;
               bit_n = 0;
               pix_n = 0;
               fb_cnt++;
               if (fb_prev) fb_wide++;
            end
            if (sclk && !sclk_prev) begin
               if (!dc) begin
                  cmd_sr = {cmd_sr[46:0], sdin};
                  cmd_n++;
               end else begin
                  word = {word[14:0], sdin};
                  bit_n++;
                  if (bit_n == 16) begin
                     if (pix_n < NPIX) words[pix_n] = word;
                     pix_n++;
                     bit_n = 0;
                  end
               end
            end
            if (busy_prev && !busy) begin
               last_cmd_n  = cmd_n;
               last_pix_n  = pix_n;
               last_cmd_sr = cmd_sr;
            end
         end
         fb_prev   = frame_begin;
         sclk_prev = sclk;
         busy_prev = busy;
      end
   end

   task automatic wait_fb(input string name);
      int n = 0;
      while (!frame_begin && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk(name, frame_begin, 1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk(name, busy, 0);
   endtask

   task automatic check_frame(input string tag);
      @(negedge clk);
      chk({tag, "_cmd_bits"}, last_cmd_n, EXP_CMD_N);
`ifdef OLED_WINDOW_CMD_EN
      chk({tag, "_header"}, last_cmd_sr, 48'h15_00_07_75_00_03);
`endif
      chk({tag, "_pix_count"}, last_pix_n, NPIX);
      for (int i = 0; i < NPIX; i++)
         chk($sformatf("%s_pix%0d", tag, i), words[i], gen(i % TW, i / TW));
   endtask

   initial begin
      int n;
      vt[0] = '{0, 0, 16'hFC00};
      vt[1] = '{1, 0, 16'h0200};
      vt[2] = '{7, 0, 16'h0E00};
      vt[3] = '{0, 1, 16'h0001};
      vt[4] = '{3, 2, 16'h0602};
      vt[5] = '{7, 3, 16'h0E03};

      rst_n  = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_sdin", sdin, 0);
      chk("rst_dc", dc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_no_fb", fb_cnt, 0);

      enable = 1'b1;
      wait_fb("fb1_timeout");
      @(negedge clk);
      chk("f1_busy", busy, 1);
      chk("f1_cs_n", cs_n, 0);
      wait_idle("f1_end_timeout");
      chk("f1_end_cs_n", cs_n, 1);
      chk("f1_end_x", x, 0);
      chk("f1_end_y", y, 0);
      n = 0;
      while (!frame_begin && n < 100) begin
         if (cs_n) n++;
         @(negedge clk);
      end
      chk("gap_len", n, TG);
      check_frame("f1");
      for (int i = 0; i < 6; i++)
         chk($sformatf("vec%0d", i), words[vt[i].py * TW + vt[i].px], vt[i].exp);

      n = 0;
      while (!(x == 7'(TW - 1) && y == 6'd0) && n < LIM) begin
         @(negedge clk);
         n++;
      end
      while (x == 7'(TW - 1) && n < LIM) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_x", x, 0);
      chk("wrap_y", y, 1);
      n = 0;
      while (pix_n < 10 && n < LIM) begin
         @(negedge clk);
         n++;
      end
      enable = 1'b0;
      wait_idle("f2_end_timeout");
      check_frame("f2");
      repeat (TG + 20) @(negedge clk);
      chk("dis_cs_n", cs_n, 1);
      chk("dis_busy", busy, 0);
      chk("dis_fb_cnt", fb_cnt, 2);

      enable = 1'b1;
      wait_fb("fb3_timeout");
      n = 0;
      while (!(dc && sclk && pix_n >= 2) && n < LIM) begin
         @(negedge clk);
         n++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_cs_n", cs_n, 1);
      chk("mrst_sclk", sclk, 0);
      chk("mrst_x", x, 0);
      chk("mrst_y", y, 0);
      chk("mrst_busy", busy, 0);
      rst_n = 1'b1;
      wait_fb("fb4_timeout");
      wait_idle("f4_end_timeout");
      check_frame("f4");
      chk("fb_single_cycle", fb_wide, 0);

      enable = 1'b0;
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
